// File: rtl/bitscan_pkg.sv
// Shared types and helpers for the iterative bit-scan encoder.
package bitscan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bitscan_iter_pe_param.sv
// Combinational highest-set-bit encoder, built as a halving tree of itself.
module pe_param
    import bitscan_pkg::*;
#(
    parameter int unsigned W = 32,
    localparam int unsigned IW = clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] out,
    output logic          v
);

    if (W == 2) begin : g_leaf
        assign out = vec[1];
        assign v   = |vec;
    end else begin : g_node
        localparam int unsigned H = W / 2;

        logic [IW-2:0] hi_idx;
        logic [IW-2:0] lo_idx;
        logic          hi_v;
        logic          lo_v;

        pe_param #(.W(H)) u_hi (
            .vec (vec[W-1:H]),
            .out (hi_idx),
            .v   (hi_v)
        );

        pe_param #(.W(H)) u_lo (
            .vec (vec[H-1:0]),
            .out (lo_idx),
            .v   (lo_v)
        );

        // Upper half wins whenever it has any set bit.
        assign v   = hi_v | lo_v;
        assign out = hi_v ? {1'b1, hi_idx} : {1'b0, lo_idx};
    end

endmodule

// File: rtl/bitscan_iter.sv
// Sequential bit scanner: emits the index of every set bit of an accepted vector, one per beat.
module bitscan_iter
    import bitscan_pkg::*;
#(
    parameter int unsigned W = 32,
    localparam int unsigned IW = clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_vec,
    input  logic          in_lsbf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          out_none,
    output logic          busy
);

    state_t        state;
    logic [W-1:0]  vec_q;
    logic          lsbf_q;
    logic          none_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [W-1:0]  scan_vec;
    logic [IW-1:0] enc_idx;
    logic          enc_v;
    logic [W-1:0]  onehot;
    logic [W-1:0]  rest;

    // LSB-first reuses the MSB-first encoder on the mirrored vector.
    always_comb begin
        scan_vec = vec_q;
        if (lsbf_q) begin
            for (int unsigned i = 0; i < W; i++) begin
                scan_vec[i] = vec_q[W-1-i];
            end
        end
    end

    pe_param #(.W(W)) u_pe (
        .vec (scan_vec),
        .out (enc_idx),
        .v   (enc_v)
    );

    always_comb begin
        out_idx = '0;
        if (enc_v) begin
            out_idx = lsbf_q ? (IW'(W - 1) - enc_idx) : enc_idx;
        end
    end

    assign onehot    = W'(1) << out_idx;
    assign rest      = vec_q & ~onehot;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = out_valid_q;
    assign out_last  = out_valid_q && (rest == '0);
    assign out_none  = out_valid_q && none_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vec_q       <= '0;
            lsbf_q      <= 1'b0;
            none_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec_q       <= in_vec;
                        lsbf_q      <= in_lsbf;
                        none_q      <= (in_vec == '0);
                        state       <= SCAN;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        vec_q <= rest;
                        if (rest == '0) begin
                            state       <= IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
